// File: rtl/basic_gates_pkg.sv
// basic_gates_pkg
// Shared definitions for the basic_gates slice: the 3-bit opcode type that
// selects which bitwise function is captured into op_q, and its constants.
package basic_gates_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_PASS = 3'd7
  } opcode_t;

endpackage

// File: rtl/basic_gates_if.sv
// basic_gates_if
// Bundles the operand/control inputs and all results of basic_gates.
//   a, b      operands (WIDTH bits)
//   en        capture enable for op_q/op_vld
//   sel       opcode selecting the registered function
//   a_*_b, not_a  combinational bitwise results
//   op_q      registered selected result, op_vld marks a valid capture
// Modports: master drives operands/controls, slave (the design) drives results.
interface basic_gates_if
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             en;
  opcode_t          sel;

  logic [WIDTH-1:0] a_and_b;
  logic [WIDTH-1:0] a_or_b;
  logic [WIDTH-1:0] a_xor_b;
  logic [WIDTH-1:0] a_nand_b;
  logic [WIDTH-1:0] a_nor_b;
  logic [WIDTH-1:0] a_xnor_b;
  logic [WIDTH-1:0] not_a;
  logic [WIDTH-1:0] op_q;
  logic             op_vld;

  modport master (
    output a, b, en, sel,
    input  a_and_b, a_or_b, a_xor_b, a_nand_b, a_nor_b, a_xnor_b, not_a,
    input  op_q, op_vld
  );

  modport slave (
    input  a, b, en, sel,
    output a_and_b, a_or_b, a_xor_b, a_nand_b, a_nor_b, a_xnor_b, not_a,
    output op_q, op_vld
  );

endinterface

// File: rtl/basic_gates_comb.sv
// basic_gates_comb
// Purely combinational bitwise functions of a and b; no clock, no reset.
//   a, b      operands (WIDTH bits)
//   a_and_b .. a_xnor_b, not_a   the seven bitwise results
// Built per bit so X/Z on one operand bit only affects that result bit.
module basic_gates_comb #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_and_b,
  output logic [WIDTH-1:0] a_or_b,
  output logic [WIDTH-1:0] a_xor_b,
  output logic [WIDTH-1:0] a_nand_b,
  output logic [WIDTH-1:0] a_nor_b,
  output logic [WIDTH-1:0] a_xnor_b,
  output logic [WIDTH-1:0] not_a
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign a_and_b[gi]  = a[gi] & b[gi];
      assign a_or_b[gi]   = a[gi] | b[gi];
      assign a_xor_b[gi]  = a[gi] ^ b[gi];
      assign a_nand_b[gi] = ~(a[gi] & b[gi]);
      assign a_nor_b[gi]  = ~(a[gi] | b[gi]);
      assign a_xnor_b[gi] = ~(a[gi] ^ b[gi]);
      assign not_a[gi]    = ~a[gi];
    end
  endgenerate

endmodule

// File: rtl/basic_gates.sv
// basic_gates
// Exposes seven combinational bitwise functions of a and b and registers one
// of them (chosen by sel) into op_q on enabled clock edges.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; clears op_q/op_vld only
//   bus    basic_gates_if slave: a, b, en, sel in; all results out
// WIDTH must match the WIDTH of the connected interface instance.
module basic_gates
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  basic_gates_if.slave  bus
);

  logic [WIDTH-1:0] and_w;
  logic [WIDTH-1:0] or_w;
  logic [WIDTH-1:0] xor_w;
  logic [WIDTH-1:0] nand_w;
  logic [WIDTH-1:0] nor_w;
  logic [WIDTH-1:0] xnor_w;
  logic [WIDTH-1:0] nota_w;

  logic [WIDTH-1:0] op_next;
  logic [WIDTH-1:0] op_q_reg;
  logic             op_vld_reg;

  basic_gates_comb #(.WIDTH(WIDTH)) u_comb (
    .a        (bus.a),
    .b        (bus.b),
    .a_and_b  (and_w),
    .a_or_b   (or_w),
    .a_xor_b  (xor_w),
    .a_nand_b (nand_w),
    .a_nor_b  (nor_w),
    .a_xnor_b (xnor_w),
    .not_a    (nota_w)
  );

  // Opcode mux. All eight codes are decoded; the default only catches an
  // unknown sel in simulation so that it shows up as X rather than a value.
  always_comb begin
    op_next = {WIDTH{1'bx}};
    case (bus.sel)
      OP_AND:  op_next = and_w;
      OP_OR:   op_next = or_w;
      OP_XOR:  op_next = xor_w;
      OP_NAND: op_next = nand_w;
      OP_NOR:  op_next = nor_w;
      OP_XNOR: op_next = xnor_w;
      OP_NOTA: op_next = nota_w;
      OP_PASS: op_next = bus.a;
      default: op_next = {WIDTH{1'bx}};
    endcase
  end

  // Reset wins over en; en=0 holds both op_q and op_vld.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q_reg   <= '0;
      op_vld_reg <= 1'b0;
    end else if (bus.en) begin
      op_q_reg   <= op_next;
      op_vld_reg <= 1'b1;
    end
  end

  assign bus.a_and_b  = and_w;
  assign bus.a_or_b   = or_w;
  assign bus.a_xor_b  = xor_w;
  assign bus.a_nand_b = nand_w;
  assign bus.a_nor_b  = nor_w;
  assign bus.a_xnor_b = xnor_w;
  assign bus.not_a    = nota_w;
  assign bus.op_q     = op_q_reg;
  assign bus.op_vld   = op_vld_reg;

endmodule

// File: tb/tb_basic_gates.sv
// tb_basic_gates
// Drives a WIDTH=1 and a WIDTH=4 instance of basic_gates with the same
// controls and compares every result with a truth-table reference model.
module tb_basic_gates;
  import basic_gates_pkg::*;

  logic clk;
  logic clk_run;
  logic rst_n;

  basic_gates_if #(.WIDTH(1)) bus1 ();
  basic_gates_if #(.WIDTH(4)) bus4 ();

  basic_gates #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  basic_gates #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];

  logic [3:0] exp_q1, exp_q4;
  logic       exp_vld1, exp_vld4;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [3:0] ref_op(input int op, input logic [3:0] a,
                                        input logic [3:0] b, input int w);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic en, input int sel,
                       input logic [3:0] a, input logic [3:0] b);
    rst_n    = rn;
    bus1.en  = en;
    bus4.en  = en;
    bus1.sel = opcode_t'(sel[2:0]);
    bus4.sel = opcode_t'(sel[2:0]);
    bus1.a   = a[0];
    bus1.b   = b[0];
    bus4.a   = a;
    bus4.b   = b;
  endtask

  task automatic check_comb(input string tag);
    logic [3:0] a4, b4, a1, b1;
    a4 = bus4.a; b4 = bus4.b;
    a1 = {3'b000, bus1.a}; b1 = {3'b000, bus1.b};
    chk({tag, "_and4"},  bus4.a_and_b,  ref_op(0, a4, b4, 4));
    chk({tag, "_or4"},   bus4.a_or_b,   ref_op(1, a4, b4, 4));
    chk({tag, "_xor4"},  bus4.a_xor_b,  ref_op(2, a4, b4, 4));
    chk({tag, "_nand4"}, bus4.a_nand_b, ref_op(3, a4, b4, 4));
    chk({tag, "_nor4"},  bus4.a_nor_b,  ref_op(4, a4, b4, 4));
    chk({tag, "_xnor4"}, bus4.a_xnor_b, ref_op(5, a4, b4, 4));
    chk({tag, "_nota4"}, bus4.not_a,    ref_op(6, a4, b4, 4));
    chk({tag, "_nand1"}, {3'b000, bus1.a_nand_b}, ref_op(3, a1, b1, 1));
    chk({tag, "_xor1"},  {3'b000, bus1.a_xor_b},  ref_op(2, a1, b1, 1));
  endtask

  // One rising edge: update the model from the inputs present at the edge,
  // then sample the registers 1 time unit later.
  task automatic edge_step(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      exp_q1 = '0; exp_vld1 = 1'b0;
      exp_q4 = '0; exp_vld4 = 1'b0;
    end else if (bus4.en) begin
      exp_q1 = ref_op(int'(bus1.sel), {3'b000, bus1.a}, {3'b000, bus1.b}, 1);
      exp_q4 = ref_op(int'(bus4.sel), bus4.a, bus4.b, 4);
      exp_vld1 = 1'b1;
      exp_vld4 = 1'b1;
    end
    #1;
    chk({tag, "_q4"},   bus4.op_q, exp_q4);
    chk({tag, "_vld4"}, {3'b000, bus4.op_vld}, {3'b000, exp_vld4});
    chk({tag, "_q1"},   {3'b000, bus1.op_q}, exp_q1);
    chk({tag, "_vld1"}, {3'b000, bus1.op_vld}, {3'b000, exp_vld1});
  endtask

  initial begin
    logic [3:0] e_nand, e_nor, e_xnor;
    logic [1:0] ab;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0110; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;
    clk = 1'b0;
    clk_run = 1'b0;
    exp_q1 = '0; exp_q4 = '0; exp_vld1 = 1'b0; exp_vld4 = 1'b0;
    drive(1'b1, 1'b0, 0, 4'h0, 4'h0);

    // WIDTH=1 truth table with the clock stopped.
    e_nand = 4'b0111; e_nor = 4'b0001; e_xnor = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      drive(1'b1, 1'b0, 0, {3'b000, ab[1]}, {3'b000, ab[0]});
      #1;
      chk($sformatf("tt_nand_ab%0d", i), {3'b000, bus1.a_nand_b}, {3'b000, e_nand[i]});
      chk($sformatf("tt_nor_ab%0d", i),  {3'b000, bus1.a_nor_b},  {3'b000, e_nor[i]});
      chk($sformatf("tt_xnor_ab%0d", i), {3'b000, bus1.a_xnor_b}, {3'b000, e_xnor[i]});
    end

    // WIDTH=4 fixed vector.
    drive(1'b1, 1'b0, 0, 4'b1100, 4'b1010);
    #1;
    chk("w4_and",  bus4.a_and_b,  4'b1000);
    chk("w4_or",   bus4.a_or_b,   4'b1110);
    chk("w4_xor",  bus4.a_xor_b,  4'b0110);
    chk("w4_nand", bus4.a_nand_b, 4'b0111);
    chk("w4_nor",  bus4.a_nor_b,  4'b0001);
    chk("w4_xnor", bus4.a_xnor_b, 4'b1001);
    chk("w4_nota", bus4.not_a,    4'b0011);

    clk_run = 1'b1;

    // Reset held over two edges with en=1; combinational outputs stay live.
    drive(1'b0, 1'b1, 2, 4'b0110, 4'b0011);
    edge_step("rst_e1");
    edge_step("rst_e2");
    chk("rst_q4_zero", bus4.op_q, 4'b0000);
    check_comb("rst_comb");

    // Directed captures: nand of 1,1 then nor of 0,0.
    drive(1'b1, 1'b1, 3, 4'hF, 4'hF);
    edge_step("nand11");
    chk("nand11_q1", {3'b000, bus1.op_q}, 4'b0000);
    chk("nand11_vld1", {3'b000, bus1.op_vld}, 4'b0001);
    drive(1'b1, 1'b1, 4, 4'h0, 4'h0);
    edge_step("nor00");
    chk("nor00_q1", {3'b000, bus1.op_q}, 4'b0001);
    chk("nor00_q4", bus4.op_q, 4'b1111);

    // en=0: inputs wander, registers hold.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      edge_step($sformatf("hold%0d", i));
      chk($sformatf("hold%0d_q4", i), bus4.op_q, 4'b1111);
    end

    // Reset asserted between edges does nothing until the edge.
    drive(1'b1, 1'b1, 1, 4'b0101, 4'b0010);
    edge_step("pre_mid");
    drive(1'b0, 1'b1, 1, 4'b0101, 4'b0010);
    #2;
    chk("mid_rst_q4", bus4.op_q, exp_q4);
    chk("mid_rst_vld4", {3'b000, bus4.op_vld}, 4'b0001);
    edge_step("rst_with_en");
    chk("rst_with_en_q4", bus4.op_q, 4'b0000);

    // First enabled edge after reset release captures.
    drive(1'b1, 1'b1, 7, 4'b1011, 4'b0000);
    edge_step("post_rst");
    chk("post_rst_q4", bus4.op_q, 4'b1011);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      drive(logic'($urandom_range(0, 19) != 0), logic'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      #1;
      check_comb($sformatf("rnd%0d", i));
      edge_step($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_gates.md
BASIC_GATES -- requirements
Module: basic_gates

Interface
REQ-001 Parameter: WIDTH, default 1, bit width of operands a and b and of every result.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  capture enable for the registered results.
- sel  input  3  opcode selecting op_q.
- a_nand_b  output  WIDTH  combinational ~(a&b).
- a_nor_b  output  WIDTH  combinational ~(a|b).
- a_xnor_b  output  WIDTH  combinational ~(a^b).
- a_and_b, a_or_b, a_xor_b  output  WIDTH each  combinational a&b, a|b, a^b.
- not_a  output  WIDTH  combinational ~a.
- op_q  output  WIDTH  registered result selected by sel.
- op_vld  output  1  registered; op_q holds a valid capture.

Function
REQ-004 The seven combinational outputs SHALL be bitwise functions of a and b only, with no clock dependence and no reset dependence.
REQ-005 The combinational outputs SHALL settle within the same simulation time step as an input change, with zero cycles of latency.
REQ-006 For WIDTH=1, the truth table over (a,b) = 00/01/10/11 SHALL be:
- a_nand_b: 1/1/1/0.
- a_nor_b: 1/0/0/0.
- a_xnor_b: 1/0/0/1.
REQ-007 The sel encoding SHALL be:
- 0 = and.
- 1 = or.
- 2 = xor.
- 3 = nand.
- 4 = nor.
- 5 = xnor.
- 6 = not_a.
- 7 = pass a.
REQ-008 On a rising clk edge with rst_n=1 and en=1, op_q SHALL load the sel-selected function of the current a and b, and op_vld SHALL become 1.
REQ-009 On a rising clk edge with rst_n=1 and en=0, op_q and op_vld SHALL hold their values.
REQ-010 The latency from a, b and sel to op_q SHALL be exactly one clock.
REQ-011 A change of sel, a or b between edges SHALL NOT affect op_q until the next enabled edge.
REQ-012 X or Z on an input SHALL NOT be masked: the result SHALL propagate the corresponding bitwise value.

Reset
REQ-013 On a rising clk edge with rst_n=0, op_q SHALL become all zeros and op_vld SHALL become 0.
REQ-014 Reset SHALL take priority over en.
REQ-015 Reset SHALL NOT affect the combinational outputs, which SHALL stay valid during reset.
REQ-016 Reset asserted between clock edges SHALL have no effect until the next rising edge.
REQ-017 The first enabled edge after rst_n returns to 1 SHALL capture normally.

Structure
REQ-018 A shared package SHALL hold the sel opcode constants (OP_AND … OP_PASS) and a 3-bit opcode typedef.
REQ-019 A single sub-module, basic_gates_comb, SHALL implement the seven combinational functions.
REQ-020 The top level SHALL contain the opcode mux and the op_q/op_vld register.

Verification
REQ-021 WIDTH=1, with no clock toggling: drive ab=00, 01, 10, 11, 1 time unit each; nand/nor/xnor SHALL be 1,1,1 / 1,0,0 / 1,0,0 / 0,0,1.
REQ-022 WIDTH=4, a=4'b1100, b=4'b1010: and=1000, or=1110, xor=0110, nand=0111, nor=0001, xnor=1001, not_a=0011.
REQ-023 Hold rst_n=0 for 2 edges with en=1: op_q=0 and op_vld=0; combinational outputs SHALL still match the truth table.
REQ-024 rst_n=1, en=1, sel=3, a=1, b=1, one edge: op_q=0, op_vld=1; then sel=4, a=0, b=0, one edge: op_q=1.
REQ-025 en=0 while a, b and sel change over 3 edges: op_q SHALL keep its last value.
REQ-026 Assert rst_n=0 in the same cycle as en=1: on the next edge op_q=0 and op_vld=0.
